// File: rtl/team1_pkg.sv
// Shared field positions and timing indices for the team1 basic computer.
package team1_pkg;

    localparam int IR_I_BIT = 15;
    localparam int ION_BIT  = 7;
    localparam int IOF_BIT  = 6;
    localparam int T_DECODE = 2;
    localparam int T_IOEXEC = 3;

    localparam logic [2:0] REGIO = 3'd7;

    // Instruction register layout: I bit, opcode at [14:12], address/IO at [11:0].
    typedef struct packed {
        logic        i;
        logic [2:0]  op;
        logic [11:0] addr;
    } ir_t;

endpackage

// File: rtl/onehot_dec_team1.sv
// Parameterized N-to-2**N one-hot decoder.
module onehot_dec_team1 #(
    parameter int N = 3
) (
    input  logic [N-1:0]      sel,
    output logic [2**N-1:0]   onehot
);

    // NOTE: assign a default before the indexed write so no latch is inferred.
    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/timing_decode_team1.sv
// Timing/decode vectors, IEN and R flip-flops for the team1 basic computer.
// Optional SC legality checker is built when TIMING_DECODE_SEQCHK_EN is defined.
module timing_decode_team1
    import team1_pkg::*;
#(
    parameter int SC_W = 4
) (
    input  logic                 clk,
    input  logic                 CLR_GLOBAL,
    input  logic [SC_W-1:0]      SC,
    input  logic [15:0]          IR,
    input  logic                 HLT,
    input  logic                 FGI,
    input  logic                 FGO,
    output logic [2**SC_W-1:0]   T,
    output logic [7:0]           D,
    output logic                 I,
    output logic [11:0]          B,
    output logic                 R,
    output logic                 r,
    output logic                 p,
    output logic                 IEN,
    output logic                 SEQ_ERR
);

    ir_t        ir_f;
    logic [7:0] d_next;
    logic       decode_en;
    logic       r_set;
    logic       r_clr;
    logic       ien_set;
    logic       ien_clr;

    assign ir_f = IR;

    onehot_dec_team1 #(.N(SC_W)) u_t_dec (
        .sel    (SC),
        .onehot (T)
    );

    onehot_dec_team1 #(.N(3)) u_d_dec (
        .sel    (ir_f.op),
        .onehot (d_next)
    );

    assign r = D[REGIO] & ~I & T[T_IOEXEC];
    assign p = D[REGIO] &  I & T[T_IOEXEC];

    // The interrupt cycle reuses T[2] to clear R, so it must not re-latch the IR.
    assign decode_en = T[T_DECODE] & ~R & ~HLT;
    assign r_set     = ~T[0] & ~T[1] & ~T[T_DECODE] & IEN & (FGI | FGO) & ~HLT;
    assign r_clr     = R & T[T_DECODE] & ~HLT;
    assign ien_set   = p & B[ION_BIT];
    assign ien_clr   = (p & B[IOF_BIT]) | (R & T[T_DECODE]);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge CLR_GLOBAL) begin
        if (CLR_GLOBAL) begin
            D   <= '0;
            I   <= 1'b0;
            B   <= '0;
            R   <= 1'b0;
            IEN <= 1'b0;
        end else begin
            if (decode_en) begin
                D <= d_next;
                I <= ir_f.i;
                B <= ir_f.addr;
            end
            if (r_set)
                R <= 1'b1;
            else if (r_clr)
                R <= 1'b0;
            if (!HLT) begin
                if (ien_clr)
                    IEN <= 1'b0;
                else if (ien_set)
                    IEN <= 1'b1;
            end
        end
    end

`ifdef TIMING_DECODE_SEQCHK_EN
    logic [SC_W-1:0] sc_prev;
    logic            sc_legal;

    // A halted counter must hold; otherwise it may hold, advance by one (wrapping) or clear.
    always_comb begin
        if (HLT)
            sc_legal = (SC == sc_prev);
        else
            sc_legal = (SC == sc_prev) || (SC == sc_prev + SC_W'(1)) || (SC == '0);
    end

    always_ff @(posedge clk or posedge CLR_GLOBAL) begin
        if (CLR_GLOBAL) begin
            sc_prev <= '0;
            SEQ_ERR <= 1'b0;
        end else begin
            if (!HLT)
                sc_prev <= SC;
            if (!sc_legal)
                SEQ_ERR <= 1'b1;
        end
    end
`else
    assign SEQ_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_timing_decode_team1.sv
// Self-checking bench for timing_decode_team1: directed test-plan steps followed by
// randomized cycles, all compared against a cycle-level reference model.
module tb_timing_decode_team1;

`ifdef TIMING_DECODE_SEQCHK_EN
    localparam bit SEQCHK = 1'b1;
`else
    localparam bit SEQCHK = 1'b0;
`endif

    logic        clk;
    logic        CLR_GLOBAL;
    logic [3:0]  SC;
    logic [15:0] IR;
    logic        HLT, FGI, FGO;
    logic [15:0] T;
    logic [7:0]  D;
    logic        I;
    logic [11:0] B;
    logic        R, r, p, IEN, SEQ_ERR;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0]  m_d;
    logic        m_i;
    logic [11:0] m_b;
    logic        m_r, m_ien, m_err;
    int          m_prev;

    timing_decode_team1 #(.SC_W(4)) dut (
        .clk        (clk),
        .CLR_GLOBAL (CLR_GLOBAL),
        .SC         (SC),
        .IR         (IR),
        .HLT        (HLT),
        .FGI        (FGI),
        .FGO        (FGO),
        .T          (T),
        .D          (D),
        .I          (I),
        .B          (B),
        .R          (R),
        .r          (r),
        .p          (p),
        .IEN        (IEN),
        .SEQ_ERR    (SEQ_ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_d = 8'h00; m_i = 1'b0; m_b = 12'h000;
        m_r = 1'b0; m_ien = 1'b0; m_err = 1'b0; m_prev = 0;
    endtask

    task automatic check_all(input string ctx);
        logic exec_io;
        exec_io = (m_d == 8'h80) && (SC == 4'd3);
        check({ctx, ".T"},   32'(T),       32'(1) << SC);
        check({ctx, ".r"},   32'(r),       32'(exec_io && !m_i));
        check({ctx, ".p"},   32'(p),       32'(exec_io && m_i));
        check({ctx, ".D"},   32'(D),       32'(m_d));
        check({ctx, ".I"},   32'(I),       32'(m_i));
        check({ctx, ".B"},   32'(B),       32'(m_b));
        check({ctx, ".R"},   32'(R),       32'(m_r));
        check({ctx, ".IEN"}, 32'(IEN),     32'(m_ien));
        check({ctx, ".ERR"}, 32'(SEQ_ERR), 32'(m_err));
    endtask

    // Advance the model across one rising edge using the inputs currently driven.
    task automatic model_edge();
        int          sc;
        logic        exec_io, n_r, n_ien, legal;
        logic [7:0]  n_d;
        logic        n_i;
        logic [11:0] n_b;
        sc = int'(SC);
        exec_io = (m_d == 8'h80) && m_i && (sc == 3);
        n_r = m_r; n_ien = m_ien; n_d = m_d; n_i = m_i; n_b = m_b;
        if (!HLT) begin
            if (sc > 2 && m_ien && (FGI || FGO))
                n_r = 1'b1;
            else if (m_r && sc == 2)
                n_r = 1'b0;
            if ((exec_io && m_b[6]) || (m_r && sc == 2))
                n_ien = 1'b0;
            else if (exec_io && m_b[7])
                n_ien = 1'b1;
            if (sc == 2 && !m_r) begin
                n_d = 8'd1 << IR[14:12];
                n_i = IR[15];
                n_b = IR[11:0];
            end
        end
        if (HLT)
            legal = (sc == m_prev);
        else
            legal = (sc == m_prev) || (sc == (m_prev + 1) % 16) || (sc == 0);
        if (SEQCHK && !legal)
            m_err = 1'b1;
        if (!HLT)
            m_prev = sc;
        m_r = n_r; m_ien = n_ien; m_d = n_d; m_i = n_i; m_b = n_b;
    endtask

    task automatic apply(input logic [3:0] s, input logic [15:0] ir_v, input logic h,
                         input logic fi, input logic fo, input string ctx);
        SC = s; IR = ir_v; HLT = h; FGI = fi; FGO = fo;
        #1;
        check_all(ctx);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run(input logic [3:0] s, input logic [15:0] ir_v, input logic h,
                       input logic fi, input logic fo, input string ctx);
        apply(s, ir_v, h, fi, fo, ctx);
        tick();
    endtask

    // Asynchronous pulse placed between clock edges.
    task automatic reset_pulse(input string ctx);
        CLR_GLOBAL = 1'b1;
        #2;
        model_reset();
        check_all(ctx);
        CLR_GLOBAL = 1'b0;
        #1;
    endtask

    initial begin
        logic [3:0]  rs;
        logic [15:0] rir;
        int          sel;

        CLR_GLOBAL = 1'b1; SC = 4'd0; IR = 16'h0000; HLT = 1'b0; FGI = 1'b0; FGO = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        check("reset.T_const", 32'(T), 32'h0001);
        CLR_GLOBAL = 1'b0;
        @(posedge clk);
        #1;

        // Fetch/decode of a register-reference instruction
        run(4'd0, 16'h7800, 0, 0, 0, "fetch0");
        run(4'd1, 16'h7800, 0, 0, 0, "fetch1");
        run(4'd2, 16'h7800, 0, 0, 0, "fetch2");
        apply(4'd3, 16'h7800, 0, 0, 0, "fetch3");
        check("fetch.D", 32'(D), 32'h80);
        check("fetch.I", 32'(I), 32'h0);
        check("fetch.B", 32'(B), 32'h800);
        check("fetch.r", 32'(r), 32'h1);
        check("fetch.p", 32'(p), 32'h0);
        tick();

        // ION, then an interrupt cycle with a different IR on the bus
        run(4'd0, 16'hF080, 0, 0, 0, "ion0");
        run(4'd1, 16'hF080, 0, 0, 0, "ion1");
        run(4'd2, 16'hF080, 0, 0, 0, "ion2");
        apply(4'd3, 16'hF080, 0, 0, 0, "ion3");
        check("ion.p", 32'(p), 32'h1);
        tick();
        apply(4'd4, 16'hF080, 0, 1, 0, "ion4");
        check("ion.IEN", 32'(IEN), 32'h1);
        tick();
        apply(4'd0, 16'h2123, 0, 1, 0, "int0");
        check("int.R_set", 32'(R), 32'h1);
        tick();
        run(4'd1, 16'h2123, 0, 1, 0, "int1");
        run(4'd2, 16'h2123, 0, 1, 0, "int2");
        apply(4'd3, 16'h2123, 0, 1, 0, "int3");
        check("int.R_clr", 32'(R), 32'h0);
        check("int.IEN_clr", 32'(IEN), 32'h0);
        check("int.D_kept", 32'(D), 32'h80);
        check("int.B_kept", 32'(B), 32'h080);
        tick();

        // HLT freezes the decode latch; SC held at 2 is legal
        run(4'd0, 16'hF080, 0, 0, 0, "hlt0");
        run(4'd1, 16'hF080, 0, 0, 0, "hlt1");
        run(4'd2, 16'hF080, 0, 0, 0, "hlt2");
        for (int k = 0; k < 3; k++)
            run(4'd2, 16'h2123, 1, 0, 0, "hlt_hold");
        check("hlt.D", 32'(D), 32'h80);
        check("hlt.B", 32'(B), 32'h080);
        check("hlt.ERR", 32'(SEQ_ERR), 32'h0);
        run(4'd3, 16'h2123, 0, 0, 0, "hlt_rel");

        // Full wrap 15 -> 0 is legal
        reset_pulse("rst_wrap");
        for (int k = 0; k < 16; k++)
            run(4'(k), 16'h1234, 0, 0, 0, "wrap");
        apply(4'd0, 16'h1234, 0, 0, 0, "wrap_end");
        check("wrap.ERR", 32'(SEQ_ERR), 32'h0);
        tick();

        // Skip 1 -> 3 is illegal and sticky
        run(4'd1, 16'h1234, 0, 0, 0, "skip1");
        run(4'd3, 16'h1234, 0, 0, 0, "skip3");
        apply(4'd0, 16'h1234, 0, 0, 0, "skip_after");
        check("skip.ERR", 32'(SEQ_ERR), 32'(SEQCHK));
        tick();
        apply(4'd1, 16'h1234, 0, 0, 0, "skip_sticky");
        check("skip.ERR_sticky", 32'(SEQ_ERR), 32'(SEQCHK));
        tick();

        // Reset mid-instruction while halted
        run(4'd2, 16'hF0C0, 0, 0, 0, "mid2");
        apply(4'd3, 16'hF0C0, 1, 0, 0, "mid3");
        reset_pulse("rst_mid");
        check("mid.D", 32'(D), 32'h00);
        check("mid.ERR", 32'(SEQ_ERR), 32'h0);
        run(4'd0, 16'h0000, 0, 0, 0, "post_rst");

        // Randomized traffic, mostly well-formed sequences
        for (int n = 0; n < 600; n++) begin
            if (n % 75 == 74)
                reset_pulse("rand_rst");
            sel = int'($urandom_range(0, 15));
            if (sel < 10)      rs = SC + 4'd1;
            else if (sel < 13) rs = SC;
            else if (sel < 14) rs = 4'd0;
            else               rs = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0)
                rir = {1'b1, 3'd7, 4'h0, 2'($urandom_range(0, 3)), 6'($urandom)};
            else
                rir = 16'($urandom);
            run(rs, rir, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timing_decode_team1.md
# timing_decode_team1

Consumer side of the sequence-counter interface in the team1 basic computer. Takes the 4-bit sequence count `SC` and the instruction register, and produces the timing and decode vectors: one-hot `T`, latched opcode `D`, indirect bit `I`, address/IO field `B`, interrupt-cycle flag `R`, and register-reference strobe `r`. The sequence-counter control uses these vectors to decide `CLR`/`INR`. The block also owns the `IEN` and `R` flip-flops and an optional `SC` legality checker.

## Interface
Parameters:
- `SC_W`, default 4: width of `SC`. The `T` width is `2**SC_W`.

Ports:
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `CLR_GLOBAL`, input, 1: reset, asynchronous, active-high.
- `SC`, input, SC_W: current sequence count.
- `IR`, input, 16: instruction register; [15] = I, [14:12] = opcode, [11:0] = address/IO bits.
- `HLT`, input, 1: halt; freezes all state in this block.
- `FGI`, `FGO`, input, 1 each: input and output device flags.
- `T`, output, 2**SC_W: one-hot timing signals.
- `D`, output, 8: one-hot opcode, latched.
- `I`, output, 1: latched indirect bit.
- `B`, output, 12: latched IR[11:0].
- `R`, output, 1: interrupt-cycle flip-flop.
- `r`, output, 1: register-reference execute strobe.
- `p`, output, 1: I/O execute strobe.
- `IEN`, output, 1: interrupt enable flip-flop.
- `SEQ_ERR`, output, 1: sticky illegal-`SC`-transition flag.

## Operation
- `T` = one-hot decode of `SC`. It is combinational, zero latency, and always exactly one bit set.
- `r` = `D[7] & ~I & T[3]`. `p` = `D[7] & I & T[3]`. Both are combinational from registered `D`/`I`.
- **Decode latch.** On an edge with `T[2] & ~R & ~HLT`:
  - `D` ← one-hot of IR[14:12].
  - `I` ← IR[15].
  - `B` ← IR[11:0].
  - Otherwise `D`, `I`, `B` hold.
- **R flip-flop.**
  - Set when `~T[0] & ~T[1] & ~T[2] & IEN & (FGI | FGO) & ~HLT`.
  - Cleared when `R & T[2] & ~HLT`.
  - The two conditions are disjoint by construction.
- **IEN flip-flop.**
  - Set when `p & B[7]` (ION).
  - Cleared when `p & B[6]` (IOF) or `R & T[2]`.
  - Clear wins over set.
  - Both are gated by `~HLT`.
- **Sequence checker.**
  - Register `sc_prev` ← `SC` on every non-HLT edge.
  - A transition is legal when `SC` equals `sc_prev`, `sc_prev + 1` (mod 2**SC_W, so 15→0 is legal), or 0.
  - While `HLT`=1, only `SC == sc_prev` is legal.
  - On any illegal transition `SEQ_ERR` sets and stays set until reset.
- **HLT** freezes `D`, `I`, `B`, `R`, `IEN`, `sc_prev`. `T`, `r`, `p` still follow their inputs.

## Timing
- **Reset values:** `D`=8'h00, `I`=0, `B`=12'h000, `R`=0, `IEN`=0, `SEQ_ERR`=0, `sc_prev`=0.
- **During reset:** `T` tracks `SC` (`SC`=0 gives `T`=16'h0001). `r`=`p`=0.
- **Reset mid-instruction:** asynchronous reset clears all state immediately, regardless of `T`/`HLT`. The first post-reset comparison is against `sc_prev`=0.
- **Latency:**
  - `D`/`I`/`B` are valid from the first cycle with `T[3]` onward. They were captured at the edge ending `T[2]`.
  - `R` is visible the cycle after its set condition.
  - The `IEN` change is visible the cycle after `p`.
  - `SEQ_ERR` asserts one cycle after the offending `SC` value is presented.
- **Interrupt cycle:** while `R`=1, the `T[2]` edge does not overwrite `D`/`I`/`B`, and it clears both `R` and `IEN` on the same edge.

## Configuration
- Macro: `TIMING_DECODE_SEQCHK_EN`.
- **Defined:** `sc_prev` and the checker are built, and `SEQ_ERR` behaves as above.
- **Undefined:** `sc_prev` and the checker are not built, and `SEQ_ERR` is tied to 0.
- All other behaviour is identical in both builds.

## Structure
- Shared package `team1_pkg` holds:
  - opcode field position (14:12) and the I bit index (15);
  - ION/IOF bit indices (7, 6);
  - timing index constants: T_DECODE=2, T_IOEXEC=3;
  - opcode constant REGIO=3'd7.
- Sub-module `onehot_dec_team1`: parameterized N-to-2**N one-hot decoder. It is instantiated twice: `SC`→`T` and IR[14:12]→`D`.

## Test plan
- **Reset and idle:** reset asserted, `SC`=0 → `T`=16'h0001, `D`=0, `R`=0, `IEN`=0, `SEQ_ERR`=0.
- **Fetch/decode:** `IR`=16'h7800, `SC` steps 0,1,2,3 → at `SC`=3, `D`=8'h80, `I`=0, `B`=12'h800, `r`=1, `p`=0.
- **ION then interrupt:**
  - `IR`=16'hF080 at `SC`=3 → `IEN`=1 next cycle.
  - With `FGI`=1 and `SC`=4 → `R`=1 next cycle.
  - `SC` 0,1,2 → `R`=0 and `IEN`=0 after the `T[2]` edge; `D` unchanged.
- **HLT freeze:** `HLT`=1 with `SC`=2 and `IR`=16'h2123 → `D`/`B` keep their prior values; `SC` held at 2 gives no `SEQ_ERR`.
- **Sequence error (macro defined):**
  - `SC` 0→1→3 → `SEQ_ERR`=1 one cycle later and it stays set.
  - `SC` 15→0 alone → no error.
  - Macro undefined → `SEQ_ERR` stays 0.
